mips_instr_encoder: RTL and testbench

//  Encoder counterpart of the control unit's instruction decoder. Accepts one

---
 rtl/mips_isa_pkg.sv | 139 +++++++++++++
 rtl/mips_sync_fifo.sv | 73 +++++++
 rtl/mips_instr_encoder.sv | 144 ++++++++++++++
 tb/tb_mips_instr_encoder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants, symbolic mnemonics and the instruction encoder function.
// The opcode/func values are the same ones the control unit's decoder uses.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  // The control unit has no SYSCALL handler, so this word stops it.
  localparam logic [31:0] HALT_WORD = {26'd0, FN_SYSCALL};

  typedef enum logic [5:0] {
    M_SLL   = 6'd0,  M_SRL  = 6'd1,  M_SRA   = 6'd2,  M_SLLV = 6'd3,
    M_SRLV  = 6'd4,  M_ADD  = 6'd5,  M_ADDU  = 6'd6,  M_SUB  = 6'd7,
    M_SUBU  = 6'd8,  M_AND  = 6'd9,  M_OR    = 6'd10, M_XOR  = 6'd11,
    M_NOR   = 6'd12, M_SLT  = 6'd13, M_MULT  = 6'd14, M_DIV  = 6'd15,
    M_JR    = 6'd16, M_ADDI = 6'd17, M_ADDIU = 6'd18, M_SLTI = 6'd19,
    M_ANDI  = 6'd20, M_ORI  = 6'd21, M_XORI  = 6'd22, M_LUI  = 6'd23,
    M_LW    = 6'd24, M_SW   = 6'd25, M_BEQ   = 6'd26, M_BNE  = 6'd27,
    M_BLEZ  = 6'd28, M_BGTZ = 6'd29, M_J     = 6'd30, M_JAL  = 6'd31,
    M_HALT  = 6'd32
  } mnemonic_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BAD_MNEM = 2'd1,
    ERR_OVERFLOW = 2'd2
  } err_code_t;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERROR
  } enc_state_t;

  typedef struct packed {
    logic        valid;
    logic        halt;
    logic [31:0] word;
  } enc_result_t;

  function automatic enc_result_t encode_instr(
    input logic [5:0]  mnem,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    enc_result_t r;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  f_rs, f_rt, f_rd, f_sh;
    logic        r_type, j_type;
    r      = '0;
    r.valid = 1'b1;
    op     = OP_RTYPE;
    fn     = '0;
    f_rs   = rs;
    f_rt   = rt;
    f_rd   = rd;
    f_sh   = shamt;
    r_type = 1'b1;
    j_type = 1'b0;
    case (mnem)
      M_SLL:   begin fn = FN_SLL;  f_rs = '0; end
      M_SRL:   begin fn = FN_SRL;  f_rs = '0; end
      M_SRA:   begin fn = FN_SRA;  f_rs = '0; end
      M_SLLV:  begin fn = FN_SLLV; f_sh = '0; end
      M_SRLV:  begin fn = FN_SRLV; f_sh = '0; end
      M_ADD:   begin fn = FN_ADD;  f_sh = '0; end
      M_ADDU:  begin fn = FN_ADDU; f_sh = '0; end
      M_SUB:   begin fn = FN_SUB;  f_sh = '0; end
      M_SUBU:  begin fn = FN_SUBU; f_sh = '0; end
      M_AND:   begin fn = FN_AND;  f_sh = '0; end
      M_OR:    begin fn = FN_OR;   f_sh = '0; end
      M_XOR:   begin fn = FN_XOR;  f_sh = '0; end
      M_NOR:   begin fn = FN_NOR;  f_sh = '0; end
      M_SLT:   begin fn = FN_SLT;  f_sh = '0; end
      M_MULT:  begin fn = FN_MULT; f_rd = '0; f_sh = '0; end
      M_DIV:   begin fn = FN_DIV;  f_rd = '0; f_sh = '0; end
      M_JR:    begin fn = FN_JR;   f_rt = '0; f_rd = '0; f_sh = '0; end
      M_ADDI:  begin r_type = 1'b0; op = OP_ADDI;  end
      M_ADDIU: begin r_type = 1'b0; op = OP_ADDIU; end
      M_SLTI:  begin r_type = 1'b0; op = OP_SLTI;  end
      M_ANDI:  begin r_type = 1'b0; op = OP_ANDI;  end
      M_ORI:   begin r_type = 1'b0; op = OP_ORI;   end
      M_XORI:  begin r_type = 1'b0; op = OP_XORI;  end
      M_LUI:   begin r_type = 1'b0; op = OP_LUI;  f_rs = '0; end
      M_LW:    begin r_type = 1'b0; op = OP_LW;    end
      M_SW:    begin r_type = 1'b0; op = OP_SW;    end
      M_BEQ:   begin r_type = 1'b0; op = OP_BEQ;   end
      M_BNE:   begin r_type = 1'b0; op = OP_BNE;   end
      M_BLEZ:  begin r_type = 1'b0; op = OP_BLEZ; f_rt = '0; end
      M_BGTZ:  begin r_type = 1'b0; op = OP_BGTZ; f_rt = '0; end
      M_J:     begin j_type = 1'b1; op = OP_J;     end
      M_JAL:   begin j_type = 1'b1; op = OP_JAL;   end
      M_HALT:  r.halt = 1'b1;
      default: r.valid = 1'b0;
    endcase
    if (r.halt)      r.word = HALT_WORD;
    else if (j_type) r.word = {op, target};
    else if (r_type) r.word = {OP_RTYPE, f_rs, f_rt, f_rd, f_sh, fn};
    else             r.word = {op, f_rs, f_rt, imm};
    return r;
  endfunction

endpackage

// File: rtl/mips_sync_fifo.sv
// Single-clock FIFO with synchronous flush; occupancy exported for the overflow check.
// Head word is read straight from storage, so rdata has no path from the write side.
module mips_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic do_push, do_pop;

  assign full  = (count_q == cnt_t'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag guards every read of stale entries.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: encodes symbolic MIPS instructions, buffers them and writes them
// sequentially into instruction memory, with HALT-terminated and error-aborted sessions.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                MEM_WORDS  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [15:0]       words_written
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  enc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       words_q, words_d;
  err_code_t         err_q, err_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [31:0]       fifo_head;
  enc_result_t       enc;
  logic              accept, writing, overflow;

  mips_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (enc.word),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign enc      = encode_instr(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
  assign in_ready = (state_q == S_RUN) && !fifo_full && !start;
  assign accept   = in_valid && in_ready;
  assign writing  = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !fifo_empty;
  // Queued words count against capacity, otherwise a full FIFO could run past MEM_WORDS.
  assign overflow = (32'(words_q) + 32'(fifo_count)) == 32'(MEM_WORDS);

  assign imem_we       = writing;
  assign imem_addr     = writing ? addr_q : '0;
  assign imem_wdata    = writing ? fifo_head : '0;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_q;
  assign words_written = words_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    words_d    = words_q;
    err_d      = err_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    if (start) begin
      fifo_flush = 1'b1;
      addr_d     = BASE_ADDR;
      words_d    = '0;
      err_d      = ERR_NONE;
      state_d    = S_RUN;
    end else begin
      // A write the memory takes in this cycle is committed even if the session aborts now.
      if (writing && imem_ready) begin
        fifo_pop = 1'b1;
        addr_d   = addr_q + ADDR_W'(4);
        words_d  = words_q + 16'd1;
      end
      case (state_q)
        S_RUN: begin
          if (accept) begin
            if (!enc.valid) begin
              err_d      = ERR_BAD_MNEM;
              state_d    = S_ERROR;
              fifo_flush = 1'b1;
            end else if (overflow) begin
              err_d      = ERR_OVERFLOW;
              state_d    = S_ERROR;
              fifo_flush = 1'b1;
            end else begin
              fifo_push = 1'b1;
              if (enc.halt) state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: if (fifo_empty) state_d = S_DONE;
        default: ;
      endcase
    end
    busy_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      words_q <= '0;
      err_q   <= ERR_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench: encoding table, back-pressure, overflow, bad mnemonic, restart and reset.
// Instance b shares every input with a but has MEM_WORDS=2 for the capacity limit.
module tb_mips_instr_encoder;
  import mips_isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, imem_ready;
  logic [5:0]  in_mnem;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        a_in_ready, a_we, a_busy, a_done, a_error;
  logic [31:0] a_addr, a_wdata;
  logic [1:0]  a_err_code;
  logic [15:0] a_ww;
  logic        b_in_ready, b_we, b_busy, b_done, b_error;
  logic [31:0] b_addr, b_wdata;
  logic [1:0]  b_err_code;
  logic [15:0] b_ww;

  mips_instr_encoder dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .imem_we(a_we), .imem_addr(a_addr),
    .imem_wdata(a_wdata), .imem_ready(imem_ready), .busy(a_busy), .done(a_done),
    .error(a_error), .err_code(a_err_code), .words_written(a_ww)
  );

  mips_instr_encoder #(.MEM_WORDS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .imem_we(b_we), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .imem_ready(imem_ready), .busy(b_busy), .done(b_done),
    .error(b_error), .err_code(b_err_code), .words_written(b_ww)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] wr_q[$];

  always @(negedge clk)
    if (!rst && a_we && imem_ready) wr_q.push_back({a_addr, a_wdata});

  typedef struct {
    mnemonic_t   mnem;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] word;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt);
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tgt; in_valid = 1'b1;
  endtask

  task automatic wait_accept(input bit use_b, input string name);
    bit got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = use_b ? b_in_ready : a_in_ready;
    end
    check({name, "_accept"}, 64'(got), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_addi(input bit use_b, input logic [15:0] imm, input string name);
    drive(M_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, imm, 26'd0);
    wait_accept(use_b, name);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = a_done;
    end
    check(name, 64'(got), 64'd1);
  endtask

  task automatic wait_ww(input logic [15:0] n_exp, input string name);
    bit got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = (a_ww == n_exp);
    end
    check(name, 64'(got), 64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_in_ready"}, 64'(a_in_ready), 64'd0);
    check({name, "_we"},       64'(a_we),       64'd0);
    check({name, "_addr"},     64'(a_addr),     64'd0);
    check({name, "_wdata"},    64'(a_wdata),    64'd0);
    check({name, "_busy"},     64'(a_busy),     64'd0);
    check({name, "_done"},     64'(a_done),     64'd0);
    check({name, "_error"},    64'(a_error),    64'd0);
    check({name, "_err_code"}, 64'(a_err_code), 64'd0);
    check({name, "_ww"},       64'(a_ww),       64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp3 [5];
    int we_seen;

    vecs[0]  = '{M_ADDI, 5'd0,  5'd8,  5'd3,  5'd1,  16'h0005, 26'd0,        32'h20080005};
    vecs[1]  = '{M_ADD,  5'd8,  5'd9,  5'd10, 5'd3,  16'hFFFF, 26'd0,        32'h01095020};
    vecs[2]  = '{M_SLL,  5'd7,  5'd2,  5'd2,  5'd4,  16'd0,    26'd0,        32'h00021100};
    vecs[3]  = '{M_J,    5'd5,  5'd6,  5'd7,  5'd8,  16'h1234, 26'h0000100,  32'h08000100};
    vecs[4]  = '{M_LUI,  5'd5,  5'd1,  5'd7,  5'd9,  16'h1234, 26'd0,        32'h3C011234};
    vecs[5]  = '{M_BLEZ, 5'd4,  5'd9,  5'd0,  5'd0,  16'hFFFE, 26'd0,        32'h1880FFFE};
    vecs[6]  = '{M_MULT, 5'd3,  5'd4,  5'd5,  5'd6,  16'd0,    26'd0,        32'h00640018};
    vecs[7]  = '{M_JR,   5'd31, 5'd1,  5'd2,  5'd3,  16'd0,    26'd0,        32'h03E00008};
    vecs[8]  = '{M_SW,   5'd29, 5'd31, 5'd0,  5'd0,  16'h0010, 26'd0,        32'hAFBF0010};
    vecs[9]  = '{M_BEQ,  5'd1,  5'd2,  5'd0,  5'd0,  16'hFFFF, 26'd0,        32'h1022FFFF};
    vecs[10] = '{M_SRA,  5'd9,  5'd3,  5'd4,  5'd31, 16'd0,    26'd0,        32'h000327C3};
    vecs[11] = '{M_NOR,  5'd1,  5'd2,  5'd3,  5'd5,  16'd0,    26'd0,        32'h00221827};
    vecs[12] = '{M_JAL,  5'd0,  5'd0,  5'd0,  5'd0,  16'd0,    26'h3FFFFFF,  32'h0FFFFFFF};
    vecs[13] = '{M_SLLV, 5'd1,  5'd2,  5'd3,  5'd7,  16'd0,    26'd0,        32'h00221804};
    exp3 = '{32'h08000100, 32'h20080005, 32'h20080005, 32'h20080005, 32'h0000000C};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; imem_ready = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    step(1);

    // IDLE refuses requests
    drive(M_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0);
    @(negedge clk);
    check("idle_in_ready", 64'(a_in_ready), 64'd0);
    step(1);
    in_valid = 1'b0;

    // Encoding table, free-flowing memory, HALT ends the session
    wr_q.delete();
    imem_ready = 1'b1;
    pulse_start();
    foreach (vecs[i]) begin
      drive(vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].tgt);
      wait_accept(1'b0, $sformatf("tbl%0d", i));
    end
    drive(M_HALT, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    wait_accept(1'b0, "tbl_halt");
    wait_done("tbl_done");
    check("tbl_busy", 64'(a_busy), 64'd0);
    check("tbl_ww", 64'(a_ww), 64'd15);
    check("tbl_nwrites", 64'(wr_q.size()), 64'd15);
    for (int i = 0; i < 14 && i < wr_q.size(); i++) begin
      check($sformatf("tbl%0d_addr", i), 64'(wr_q[i][63:32]), 64'(4 * i));
      check($sformatf("tbl%0d_data", i), 64'(wr_q[i][31:0]), 64'(vecs[i].word));
    end
    if (wr_q.size() == 15) check("tbl_halt_word", 64'(wr_q[14]), {32'd56, 32'h0000000C});

    // Back-pressure: one-cycle latency, FIFO fills, outputs hold until imem_ready
    step(1);
    wr_q.delete();
    imem_ready = 1'b0;
    pulse_start();
    drive(M_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h100);
    @(negedge clk);
    check("lat_we_same_cycle", 64'(a_we), 64'd0);
    check("lat_ready", 64'(a_in_ready), 64'd1);
    step(1);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_we_next", 64'(a_we), 64'd1);
    step(1);
    for (int k = 0; k < 3; k++) send_addi(1'b0, 16'd5, $sformatf("bp_addi%0d", k));
    drive(M_HALT, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_ready%0d", k), 64'(a_in_ready), 64'd0);
      check($sformatf("bp_hold%0d", k), {31'd0, a_we, a_addr}, {31'd0, 1'b1, 32'd0});
      check($sformatf("bp_data%0d", k), 64'(a_wdata), 64'h08000100);
    end
    imem_ready = 1'b1;
    wait_accept(1'b0, "bp_halt");
    wait_done("bp_done");
    check("bp_ww", 64'(a_ww), 64'd5);
    check("bp_nwrites", 64'(wr_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < wr_q.size(); i++)
      check($sformatf("bp%0d_write", i), wr_q[i], {32'(4 * i), exp3[i]});

    // Capacity limit on the MEM_WORDS=2 instance
    step(1);
    pulse_start();
    for (int k = 0; k < 3; k++) send_addi(1'b1, 16'd5, $sformatf("ovf_addi%0d", k));
    step(3);
    @(negedge clk);
    check("ovf_error", 64'(b_error), 64'd1);
    check("ovf_err_code", 64'(b_err_code), 64'd2);
    check("ovf_ww", 64'(b_ww), 64'd2);
    check("ovf_we", 64'(b_we), 64'd0);
    check("ovf_busy_done", {b_busy, b_done}, 64'd0);
    check("ovf_addr_data", {b_addr, b_wdata}, 64'd0);

    // Illegal mnemonic after one good word
    step(1);
    wr_q.delete();
    pulse_start();
    send_addi(1'b0, 16'd5, "bad_addi");
    drive(6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    wait_accept(1'b0, "bad_mnem");
    we_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (a_we) we_seen++;
    end
    check("bad_no_we", 64'(we_seen), 64'd0);
    check("bad_error", 64'(a_error), 64'd1);
    check("bad_err_code", 64'(a_err_code), 64'd1);
    check("bad_ww", 64'(a_ww), 64'd1);
    check("bad_nwrites", 64'(wr_q.size()), 64'd1);
    check("bad_busy", 64'(a_busy), 64'd0);

    // Restart mid-RUN with words queued, then async reset mid-write
    step(1);
    pulse_start();
    send_addi(1'b0, 16'd1, "rs_a0");
    send_addi(1'b0, 16'd2, "rs_a1");
    wait_ww(16'd2, "rs_ww2");
    imem_ready = 1'b0;
    step(1);
    for (int k = 0; k < 3; k++) send_addi(1'b0, 16'd3, $sformatf("rs_q%0d", k));
    @(negedge clk);
    check("rs_pending", {31'd0, a_we, a_addr}, {31'd0, 1'b1, 32'd8});
    step(1);
    start = 1'b1;
    @(negedge clk);
    check("rs_ready_during_start", 64'(a_in_ready), 64'd0);
    step(1);
    start = 1'b0;
    @(negedge clk);
    check("rs_ww0", 64'(a_ww), 64'd0);
    check("rs_we0", 64'(a_we), 64'd0);
    check("rs_busy", {a_busy, a_error, a_done}, {61'd0, 3'b100});
    wr_q.delete();
    imem_ready = 1'b1;
    step(1);
    send_addi(1'b0, 16'd7, "rs_new");
    step(3);
    check("rs_nwrites", 64'(wr_q.size()), 64'd1);
    if (wr_q.size() > 0) check("rs_first_write", wr_q[0], {32'd0, 32'h20080007});

    imem_ready = 1'b0;
    send_addi(1'b0, 16'd9, "rst_addi");
    @(negedge clk);
    check("rst_we_before", 64'(a_we), 64'd1);
    #1 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
